// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared bus, queue entry and fetch state types for the fetch front end
package fetch_queue_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_t;

  function automatic u64 pc_step(input u64 pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - circular buffer of fetched {pc, instr} entries
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decoupled instruction fetch: PC generation, ibus requests, redirect handling
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output ibus_req_t     ireq,
  input  ibus_resp_t    iresp,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [CW-1:0] count
);

  fetch_state_t  r_state;
  u64            r_pc;
  u64            r_addr_latched;

  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ_next;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;
  logic          w_unused;

  assign w_unused   = iresp.addr_ok;
  assign w_flush    = redirect_valid;
  assign w_pop      = out_valid && out_ready && !redirect_valid;
  assign w_push     = (r_state == FETCH) && iresp.data_ok && !redirect_valid;
  assign w_occ_next = w_count + CW'(w_push) - CW'(w_pop);
  assign w_entry    = '{pc: r_pc, instr: iresp.data};

  fetch_queue_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_entry(w_entry),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .o_head (w_head),
    .o_count(w_count)
  );

  // A request on the bus is never withdrawn: a redirect without data_ok parks
  // the old address in DISCARD until its response arrives and is thrown away.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pc           <= PC_RESET;
      r_addr_latched <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else if (w_count < CW'(DEPTH)) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (iresp.data_ok) begin
              r_state <= IDLE;
            end else begin
              r_addr_latched <= r_pc;
              r_state        <= DISCARD;
            end
          end else if (iresp.data_ok) begin
            r_pc    <= pc_step(r_pc);
            r_state <= (w_occ_next < CW'(DEPTH)) ? FETCH : IDLE;
          end
        end
        DISCARD: begin
          if (redirect_valid) r_pc <= redirect_pc;
          if (iresp.data_ok)  r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ireq.valid = (r_state != IDLE);
  assign ireq.addr  = (r_state == DISCARD) ? r_addr_latched :
                      (r_state == FETCH)   ? r_pc : '0;

  assign count     = w_count;
  assign out_valid = (w_count != '0);
  assign out_pc    = out_valid ? w_head.pc : '0;
  assign out_instr = out_valid ? w_head.instr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          CW       = 3;
  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  ibus_req_t     ireq;
  ibus_resp_t    iresp;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model: the queue contents, the next PC, and whether a bus request is
  // outstanding (and whether its data is already known to be unwanted).
  ent_t        m_q[$];
  logic [63:0] m_pc       = 64'd0;
  logic [63:0] m_req_addr = 64'd0;
  logic        m_busy     = 1'b0;
  logic        m_stale    = 1'b0;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_RESET(PC_RESET)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq          (ireq),
    .iresp         (iresp),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .count         (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    chk("ireq_valid", 64'(ireq.valid), 64'(m_busy));
    chk("ireq_addr",  ireq.addr, m_busy ? m_req_addr : 64'd0);
    chk("count",      64'(count), 64'(sz));
    chk("out_valid",  64'(out_valid), 64'(sz != 0));
    chk("out_pc",     out_pc, (sz != 0) ? m_q[0].pc : 64'd0);
    chk("out_instr",  64'(out_instr), (sz != 0) ? 64'(m_q[0].instr) : 64'd0);
  endtask

  task automatic model_next(input logic r, input logic dok, input logic rv,
                            input logic [63:0] rpc, input logic rdy);
    int   sz;
    logic pop;
    ent_t e;
    sz  = m_q.size();
    pop = (sz > 0) && rdy && !rv;
    if (r) begin
      m_q.delete();
      m_pc    = PC_RESET;
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (m_busy) begin
        if (dok) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_busy) begin
        if (sz < DEPTH) begin
          m_busy     = 1'b1;
          m_stale    = 1'b0;
          m_req_addr = m_pc;
        end
      end else if (dok) begin
        if (m_stale) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          e.pc    = m_pc;
          e.instr = instr_of(m_req_addr);
          m_q.push_back(e);
          m_pc = m_pc + 64'd4;
          if (m_q.size() < DEPTH) m_req_addr = m_pc;
          else m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic dok, input logic rv,
                      input logic [63:0] rpc, input logic rdy);
    reset          = r;
    iresp.data_ok  = dok;
    iresp.addr_ok  = dok;
    iresp.data     = instr_of(m_req_addr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_next(r, dok, rv, rpc, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // reset
    step(1, 0, 0, 64'd0, 0);
    step(1, 0, 0, 64'd0, 0);
    chk("rst_valid", 64'(ireq.valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);

    // streaming, one instruction per cycle
    step(0, 1, 0, 64'd0, 1);
    chk("t1_addr", ireq.addr, 64'h8000_0000);
    step(0, 1, 0, 64'd0, 1);
    chk("t1_pc0", out_pc, 64'h8000_0000);
    step(0, 1, 0, 64'd0, 1);
    chk("t1_pc1", out_pc, 64'h8000_0004);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'd0, 1);

    // consumer stalls: queue fills to DEPTH and requests stop
    for (int i = 0; i < 6; i++) step(0, 1, 0, 64'd0, 0);
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_valid", 64'(ireq.valid), 64'd0);
    step(0, 1, 0, 64'd0, 1);
    step(0, 1, 0, 64'd0, 1);
    chk("t2_resume_valid", 64'(ireq.valid), 64'd1);
    chk("t2_resume_addr", ireq.addr, 64'h8000_0020);
    step(0, 1, 0, 64'd0, 1);
    step(0, 1, 0, 64'd0, 1);

    // redirect while the response is delayed
    step(0, 0, 1, 64'h8000_0100, 1);
    chk("t3_flush_count", 64'(count), 64'd0);
    chk("t3_hold_addr0", ireq.addr, 64'h8000_0028);
    step(0, 0, 0, 64'd0, 1);
    step(0, 0, 0, 64'd0, 1);
    chk("t3_hold_addr2", ireq.addr, 64'h8000_0028);
    step(0, 1, 0, 64'd0, 1);
    chk("t3_drop_count", 64'(count), 64'd0);
    chk("t3_drop_valid", 64'(ireq.valid), 64'd0);
    step(0, 1, 0, 64'd0, 1);
    chk("t3_new_addr", ireq.addr, 64'h8000_0100);
    step(0, 1, 0, 64'd0, 1);
    chk("t3_new_pc", out_pc, 64'h8000_0100);
    step(0, 1, 0, 64'd0, 1);

    // redirect and data_ok in the same cycle
    step(0, 1, 1, 64'h8000_0200, 1);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(ireq.valid), 64'd0);
    step(0, 0, 0, 64'd0, 1);
    chk("t4_addr", ireq.addr, 64'h8000_0200);

    // push and pop together at count 2, across pointer wrap
    step(0, 1, 0, 64'd0, 0);
    step(0, 1, 0, 64'd0, 0);
    chk("t5_count2", 64'(count), 64'd2);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 64'd0, 1);
    chk("t5_count_hold", 64'(count), 64'd2);
    chk("t5_head", out_pc, 64'h8000_0218);

    // PC wraps modulo 2^64
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    step(0, 1, 0, 64'd0, 1);
    chk("t6_top_addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, 64'd0, 1);
    chk("t6_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_wrap_addr", ireq.addr, 64'd0);
    step(0, 1, 0, 64'd0, 1);
    chk("t6_wrap_pc", out_pc, 64'd0);

    // reset during a pending request, then a stale data_ok
    step(0, 0, 0, 64'd0, 1);
    step(0, 0, 0, 64'd0, 1);
    step(1, 0, 0, 64'd0, 1);
    chk("t7_rst_valid", 64'(ireq.valid), 64'd0);
    chk("t7_rst_count", 64'(count), 64'd0);
    step(0, 1, 0, 64'd0, 1);
    chk("t7_stale_count", 64'(count), 64'd0);
    chk("t7_addr", ireq.addr, 64'h8000_0000);
    step(0, 1, 0, 64'd0, 1);
    chk("t7_pc", out_pc, 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
